win_mac_stream: RTL and testbench

//  - Streaming windowed multiply-add: for each qualifying input sample, computes

---
 rtl/win_mac_stream_if.sv | 24 ++
 rtl/win_mac_stream.sv | 56 +++++
 tb/tb_win_mac_stream.sv | 139 +++++++++++++
 3 files changed

// File: rtl/win_mac_stream_if.sv
// win_mac_stream_if: sample stream in, windowed multiply-add result out.
//   master drives validi/flush/data_in and observes valido/data_out/run_cnt.
//   slave is the datapath side.
//   WIN_MAC_SAT_EN adds sat_o, which flags a clamped result.
interface win_mac_stream_if #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32,
    parameter int RUN   = 3
);
    logic                       validi;
    logic                       flush;
    logic [WIDTH-1:0]           data_in;
    logic                       valido;
    logic [OUT_W-1:0]           data_out;
    logic [$clog2(RUN+1)-1:0]   run_cnt;
`ifdef WIN_MAC_SAT_EN
    logic                       sat_o;
    modport master (output validi, flush, data_in, input valido, data_out, run_cnt, sat_o);
    modport slave  (input validi, flush, data_in, output valido, data_out, run_cnt, sat_o);
`else
    modport master (output validi, flush, data_in, input valido, data_out, run_cnt);
    modport slave  (input validi, flush, data_in, output valido, data_out, run_cnt);
`endif
endinterface

// File: rtl/win_mac_stream.sv
// win_mac_stream: streaming data_out = s2*s1 + data_in, qualified after RUN consecutive valids.
//   clk, rst : clock and synchronous active-high reset
//   bus      : win_mac_stream_if.slave (validi, flush, data_in -> valido, data_out, run_cnt)
//   WIN_MAC_SAT_EN : saturate instead of wrap, and drive bus.sat_o
module win_mac_stream #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32,
    parameter int RUN   = 3
) (
    input logic             clk,
    input logic             rst,
    win_mac_stream_if.slave bus
);
    localparam int CW = $clog2(RUN+1);
    logic [WIDTH-1:0]   s1, s2;
    logic [2*WIDTH-1:0] prod;
    logic [OUT_W-1:0]   res;
    logic               q;
    assign q    = bus.validi & ~bus.flush & (bus.run_cnt >= CW'(RUN-1));
    assign prod = (2*WIDTH)'(s2) * (2*WIDTH)'(s1);
`ifdef WIN_MAC_SAT_EN
    logic [2*WIDTH:0] sum;
    logic             clamp;
    assign sum   = {1'b0, prod} + (2*WIDTH+1)'(bus.data_in);
    assign clamp = (sum >> OUT_W) != '0;
    assign res   = clamp ? '1 : OUT_W'(sum);
    always_ff @(posedge clk)
        bus.sat_o <= rst ? 1'b0 : q & clamp;
`else
    assign res = OUT_W'({1'b0, prod} + (2*WIDTH+1)'(bus.data_in));
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= '0;
            s2           <= '0;
            bus.run_cnt  <= '0;
            bus.valido   <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.valido <= q;
            if (q)
                bus.data_out <= res;
            // flush starts a new run; a same-cycle sample becomes its first entry
            if (bus.flush) begin
                s1 <= bus.validi ? bus.data_in : '0;
                s2 <= '0;
            end else if (bus.validi) begin
                s2 <= s1;
                s1 <= bus.data_in;
            end
            bus.run_cnt <= bus.flush ? CW'(bus.validi) :
                           !bus.validi ? '0 :
                           bus.run_cnt == CW'(RUN) ? bus.run_cnt : bus.run_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_win_mac_stream.sv
// tb_win_mac_stream: directed and random stimulus against RUN=3 and RUN=5 instances with a queue-based model.
module tb_win_mac_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    win_mac_stream_if #(.WIDTH(32), .OUT_W(32), .RUN(3)) b3 ();
    win_mac_stream_if #(.WIDTH(32), .OUT_W(32), .RUN(5)) b5 ();
    win_mac_stream #(.WIDTH(32), .OUT_W(32), .RUN(3)) d3 (.clk(clk), .rst(rst), .bus(b3.slave));
    win_mac_stream #(.WIDTH(32), .OUT_W(32), .RUN(5)) d5 (.clk(clk), .rst(rst), .bus(b5.slave));

    logic [31:0] smp[$];
    int          st[2];
    int          run_k[2] = '{3, 5};
    logic        ev[2];
    logic [31:0] ed[2];
    logic        es[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic f, input logic r, input logic [31:0] d);
        logic [64:0] full;
        logic [31:0] a, b;
        logic        q, big;
        @(negedge clk);
        rst = r;
        b3.validi = v; b3.flush = f; b3.data_in = d;
        b5.validi = v; b5.flush = f; b5.data_in = d;
        a    = smp.size() >= 2 ? smp[smp.size()-2] : 32'd0;
        b    = smp.size() >= 1 ? smp[smp.size()-1] : 32'd0;
        full = 65'(a) * 65'(b) + 65'(d);
        big  = full >= 65'h1_0000_0000;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                ev[k] = 1'b0; ed[k] = '0; es[k] = 1'b0; st[k] = 0;
            end else begin
                q = v && !f && (st[k] >= run_k[k] - 1);
                ev[k] = q;
`ifdef WIN_MAC_SAT_EN
                es[k] = q && big;
                if (q) ed[k] = big ? 32'hFFFF_FFFF : full[31:0];
`else
                es[k] = 1'b0;
                if (q) ed[k] = full[31:0];
`endif
                st[k] = f ? int'(v) : !v ? 0 : (st[k] + 1 > run_k[k] ? run_k[k] : st[k] + 1);
            end
        end
        if (r || f) smp.delete();
        if (!r && v) smp.push_back(d);
        if (smp.size() > 2) void'(smp.pop_front());
        @(posedge clk);
        #1;
        check("valido_r3", 64'(b3.valido), 64'(ev[0]));
        check("data_r3", 64'(b3.data_out), 64'(ed[0]));
        check("cnt_r3", 64'(b3.run_cnt), 64'(st[0]));
        check("valido_r5", 64'(b5.valido), 64'(ev[1]));
        check("data_r5", 64'(b5.data_out), 64'(ed[1]));
        check("cnt_r5", 64'(b5.run_cnt), 64'(st[1]));
`ifdef WIN_MAC_SAT_EN
        check("sat_r3", 64'(b3.sat_o), 64'(es[0]));
        check("sat_r5", 64'(b5.sat_o), 64'(es[1]));
`endif
    endtask

    initial begin
        logic v, f, r;
        logic [31:0] d;
        b3.validi = 0; b3.flush = 0; b3.data_in = '0;
        b5.validi = 0; b5.flush = 0; b5.data_in = '0;
        step(0, 0, 1, 0);
        step(1, 0, 1, 5);
        check("reset_data", 64'(b3.data_out), 0);
        // 2,3,4 then 5
        step(1, 0, 0, 2); step(1, 0, 0, 3); step(1, 0, 0, 4);
        check("run3_first", 64'(b3.data_out), 10);
        step(1, 0, 0, 5);
        check("run3_next", 64'(b3.data_out), 17);
        // reset mid-stream then 1,2,3
        step(1, 0, 1, 7);
        check("rst_valido", 64'(b3.valido), 0);
        check("rst_cnt", 64'(b3.run_cnt), 0);
        step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
        check("after_rst", 64'(b3.data_out), 5);
        // 2,3,gap,4,6,7
        step(0, 0, 0, 0);
        step(1, 0, 0, 2); step(1, 0, 0, 3); step(0, 0, 0, 0); step(1, 0, 0, 4);
        check("gap_hold", 64'(b3.valido), 0);
        step(1, 0, 0, 6);
        check("gap_hold2", 64'(b3.valido), 0);
        step(1, 0, 0, 7);
        check("gap_window", 64'(b3.data_out), 31);
        // flush with valid sample 9, then 1,1
        step(1, 0, 0, 2);
        step(1, 1, 0, 9);
        check("flush_valido", 64'(b3.valido), 0);
        check("flush_cnt", 64'(b3.run_cnt), 1);
        step(1, 0, 0, 1); step(1, 0, 0, 1);
        check("flush_window", 64'(b3.data_out), 10);
        // wrap / saturate boundary
        step(0, 0, 0, 0);
        step(1, 0, 0, 32'h10000); step(1, 0, 0, 32'h10000); step(1, 0, 0, 1);
`ifdef WIN_MAC_SAT_EN
        check("sat_data", 64'(b3.data_out), 64'hFFFF_FFFF);
        check("sat_flag", 64'(b3.sat_o), 1);
`else
        check("wrap_data", 64'(b3.data_out), 1);
`endif
        // RUN=5: four valids then gap, then five valids
        step(0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 32'(i));
        step(0, 0, 0, 0);
        check("r5_no_valido", 64'(b5.valido), 0);
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 32'(i));
        check("r5_valido", 64'(b5.valido), 1);
        check("r5_data", 64'(b5.data_out), 17);
        // flush without a sample
        step(0, 1, 0, 0);
        check("flush_idle_cnt", 64'(b3.run_cnt), 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            v = $urandom_range(0, 9) < 8;
            f = $urandom_range(0, 29) == 0;
            r = $urandom_range(0, 99) == 0;
            d = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 1000));
            step(v, f, r, d);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
